// File: rtl/signed_subtractor_pipe_if.sv
// Handshake bundle for signed_subtractor_pipe: operand side, result side and saturation debug readout.
// No logic of its own; the parameters must match those given to signed_subtractor_pipe.
// The master modport drives operands, out_ready and sat_clear. The slave modport (the subtractor) drives the results.
//
// Signals:
//   in_valid/in_ready/a/b      operand handshake (a = minuend, b = subtrahend)
//   out_valid/out_ready/out    result handshake
//   out_sat                    result was clamped
//   sat_clear/sat_count        debug counter of delivered saturated results
interface signed_subtractor_pipe_if #(
  parameter int IN1_WIDTH = 20,
  parameter int IN2_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic [IN1_WIDTH-1:0] a;
  logic [IN2_WIDTH-1:0] b;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 out_sat;
  logic                 sat_clear;
  logic [CNT_WIDTH-1:0] sat_count;

  modport master (
    output in_valid, a, b, out_ready, sat_clear,
    input  in_ready, out_valid, out, out_sat, sat_count
  );

  modport slave (
    input  in_valid, a, b, out_ready, sat_clear,
    output in_ready, out_valid, out, out_sat, sat_count
  );

endinterface

// File: rtl/signed_subtractor_pipe.sv
// Two-stage pipelined signed subtractor out = a - b, with optional saturation to OUT_WIDTH.
// The latency is 2 cycles from input transfer to out_valid, and throughput is 1 result per cycle.
// Under backpressure, out_ready=0 holds out/out_sat. Stage 1 stalls when full, and in_ready is the only combinational path (from out_ready).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset; drops everything in flight
//   bus        signed_subtractor_pipe_if.slave (operands, result, sat_clear/sat_count)
//
// Build option: define SIGNED_SUB_SAT_EN to clamp the difference and track saturation.
// Without it the difference wraps to its low OUT_WIDTH bits, and out_sat and sat_count read 0.
module signed_subtractor_pipe #(
  parameter int IN1_WIDTH = 20,
  parameter int IN2_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  signed_subtractor_pipe_if.slave bus
);

  // One guard bit above the wider operand makes the difference exact.
  localparam int W = ((IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH) + 1;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic out_valid_q;
  logic s2_take;
  logic s1_take;

  // Stage 2 can load when it is empty or its current result leaves this cycle.
  // Stage 1 can load when it is empty or it can pass its content forward.
  assign s2_take = !out_valid_q || bus.out_ready;
  assign s1_take = !s1_valid || s2_take;

  assign bus.in_ready  = s1_take;
  assign bus.out_valid = out_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: exact W-bit difference
  // ---------------------------------------------------------------------------
  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] diff;
  logic [W-1:0] s1_diff;

  assign a_ext = W'($signed(bus.a));
  assign b_ext = W'($signed(bus.b));
  assign diff  = a_ext - b_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else if (s1_take) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_diff <= diff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Range reduction from W bits down to OUT_WIDTH (between the stages)
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] s1_res;

`ifdef SIGNED_SUB_SAT_EN
  logic s1_sat;

  generate
    if (OUT_WIDTH >= W) begin : g_fit
      // Every difference is representable, so sign-extend and never flag.
      assign s1_res = OUT_WIDTH'($signed(s1_diff));
      assign s1_sat = 1'b0;
    end else begin : g_clamp
      localparam int TOPW = W - OUT_WIDTH + 1;
      localparam logic [OUT_WIDTH-1:0] RES_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      localparam logic [OUT_WIDTH-1:0] RES_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

      logic [TOPW-1:0] top_bits;
      logic            fits;

      // The value fits iff every bit from the output sign bit upward equals the true sign.
      assign top_bits = s1_diff[W-1:OUT_WIDTH-1];
      assign fits     = (top_bits == {TOPW{1'b0}}) || (top_bits == {TOPW{1'b1}});
      assign s1_sat   = !fits;
      assign s1_res   = fits ? s1_diff[OUT_WIDTH-1:0]
                             : (s1_diff[W-1] ? RES_MIN : RES_MAX);
    end
  endgenerate
`else
  generate
    if (OUT_WIDTH >= W) begin : g_fit
      assign s1_res = OUT_WIDTH'($signed(s1_diff));
    end else begin : g_wrap
      // Two's-complement wrap: the bits above the output width are discarded.
      logic [W-OUT_WIDTH-1:0] unused_hi_bits;
      assign unused_hi_bits = s1_diff[W-1:OUT_WIDTH];
      assign s1_res         = s1_diff[OUT_WIDTH-1:0];
    end
  endgenerate
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: output register
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (s2_take) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_q <= s1_res;
      end
    end
  end

  assign bus.out = out_q;

  // ---------------------------------------------------------------------------
  // Saturation flag and event counter
  // ---------------------------------------------------------------------------
`ifdef SIGNED_SUB_SAT_EN
  logic                 out_sat_q;
  logic [CNT_WIDTH-1:0] sat_cnt;
  logic                 out_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_sat_q <= 1'b0;
    end else if (s2_take && s1_valid) begin
      out_sat_q <= s1_sat;
    end
  end

  assign out_xfer = out_valid_q && bus.out_ready;

  // Only delivered results count. The counter sticks at all-ones, and clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt <= '0;
    end else if (bus.sat_clear) begin
      sat_cnt <= '0;
    end else if (out_xfer && out_sat_q && (sat_cnt != {CNT_WIDTH{1'b1}})) begin
      sat_cnt <= sat_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.out_sat   = out_sat_q;
  assign bus.sat_count = sat_cnt;
`else
  logic unused_sat_clear;
  assign unused_sat_clear = bus.sat_clear;
  assign bus.out_sat      = 1'b0;
  assign bus.sat_count    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // A result that is stalled must stay put until it is accepted.
  a_out_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_q)));

  // The input is refused only when both stages are full and the output is stalled.
  a_ready_rule: assert property (@(posedge clk) disable iff (!reset_n)
    (!bus.in_ready) |-> (s1_valid && out_valid_q && !bus.out_ready));

endmodule

// File: tb/tb_signed_subtractor_pipe.sv
// Self-checking bench for signed_subtractor_pipe at default parameters.
// Uses directed vectors with hand-computed results, plus a free-running reference model and compare process.
// Stimulus runs with out_ready high, through a backpressure window, and through a mid-flight reset.
module tb_signed_subtractor_pipe;

`ifdef SIGNED_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  signed_subtractor_pipe_if bus ();

  signed_subtractor_pipe dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] o;
    logic        s;
  } exp_t;

  int          n_checks;
  int          n_fail;
  exp_t        q[$];
  int          items;
  logic [15:0] model_cnt;
  logic        prev_stall;
  logic [31:0] prev_out;
  logic        prev_sat;
  logic        stream_on;
  logic [31:0] rx[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer difference, then clamp or wrap into 32 bits.
  function automatic void calc(input logic [19:0] a, input logic [31:0] b,
                               output logic [31:0] o, output logic s);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    s = 1'b0;
    o = d[31:0];
    if (SAT) begin
      if (d > 64'sd2147483647) begin
        o = 32'h7FFF_FFFF;
        s = 1'b1;
      end else if (d < -64'sd2147483648) begin
        o = 32'h8000_0000;
        s = 1'b1;
      end
    end
  endfunction

  // Compare process. It samples on the falling edge.
  // items is the number of results the DUT currently holds, which is enough to predict in_ready.
  logic        m_push;
  logic        m_pop;
  logic [31:0] m_o;
  logic        m_s;
  exp_t        m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        items      = 0;
        model_cnt  = '0;
        prev_stall = 1'b0;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sat_count", bus.sat_count, 16'd0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
      end else begin
        m_push = bus.in_valid && bus.in_ready;
        m_pop  = bus.out_valid && bus.out_ready && (items > 0);
        chk("in_ready", bus.in_ready, !(items == 2 && !bus.out_ready));
        if (items == 0) chk("idle_out_valid", bus.out_valid, 1'b0);
        if (prev_stall) begin
          chk("stall_valid", bus.out_valid, 1'b1);
          chk("stall_out", bus.out, prev_out);
          chk("stall_sat", bus.out_sat, prev_sat);
        end
        chk("sat_count", bus.sat_count, model_cnt);
        if (m_pop) begin
          m_e = q.pop_front();
          chk("out", bus.out, m_e.o);
          chk("out_sat", bus.out_sat, m_e.s);
          if (stream_on) rx.push_back(bus.out);
          if (m_e.s && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
        if (bus.sat_clear) model_cnt = '0;
        if (m_push) begin
          calc(bus.a, bus.b, m_o, m_s);
          m_e = '{o: m_o, s: m_s};
          q.push_back(m_e);
        end
        items      = items + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = bus.out;
        prev_sat   = bus.out_sat;
      end
    end
  end

  // Sends one vector into an empty pipeline with out_ready high, then pins latency and value.
  // Called and returns at posedge+1; on return the result is valid and leaves on the next edge.
  task automatic send(input string name, input logic [19:0] a, input logic [31:0] b,
                      input logic [31:0] eo, input logic es);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({name, "_lat1"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    chk({name, "_lat2"}, bus.out_valid, 1'b1);
    chk({name, "_out"}, bus.out, eo);
    chk({name, "_sat"}, bus.out_sat, es);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int   idx;
  logic fire;
  logic saw_block;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    stream_on     = 1'b0;
    items         = 0;
    model_cnt     = '0;
    prev_stall    = 1'b0;
    reset_n       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    bus.sat_clear = 1'b0;

    #1 reset_n = 1'b0;
    #1;
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out", bus.out, 32'd0);
    chk("reset_out_sat", bus.out_sat, 1'b0);
    chk("reset_sat_count", bus.sat_count, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 5 - 7 = -2
    send("sub", 20'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    step();
    // -1 - (2^31-1) = -2^31 exactly representable
    send("edge", 20'hFFFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    step();
    // 0 - (-2^31) = 2^31: clamps when saturating, wraps to 0x80000000 otherwise
    send("pos_clamp", 20'd0, 32'h8000_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT);
    step();
    chk("cnt_after_pos", bus.sat_count, SAT ? 16'd1 : 16'd0);
    // -2 - (2^31-1) = -2^31-1: clamps low, or wraps to 0x7FFFFFFF
    send("neg_clamp", 20'hFFFFE, 32'h7FFF_FFFF, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, SAT);
    step();
    chk("cnt_after_neg", bus.sat_count, SAT ? 16'd2 : 16'd0);
    // Clear coincident with another saturated transfer: clear wins.
    send("clr_clamp", 20'd0, 32'h8000_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT);
    bus.sat_clear = 1'b1;
    step();
    bus.sat_clear = 1'b0;
    chk("cnt_clear_wins", bus.sat_count, 16'd0);

    // Backpressure: stream 1..8 - 0, out_ready low during cycles 3..6.
    rx.delete();
    stream_on = 1'b1;
    idx       = 1;
    saw_block = 1'b0;
    for (int c = 0; c < 40 && !(idx > 8 && items == 0); c++) begin
      bus.in_valid  = (idx <= 8);
      bus.a         = 20'(idx);
      bus.b         = 32'd0;
      bus.out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    stream_on = 1'b0;
    chk("bp_in_ready_low", saw_block, 1'b1);
    chk("bp_count", rx.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rx.size()) chk("bp_order", rx[i], 64'(i + 1));
    end

    // Reset with two results in flight.
    send("pre_rst", 20'd0, 32'h8000_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT);
    step();
    chk("pre_rst_cnt", bus.sat_count, SAT ? 16'd1 : 16'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 20'd3;
    bus.b         = 32'd1;
    step();
    bus.a = 20'd4;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    chk("pre_rst_out", bus.out, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.out_valid, 1'b0);
    chk("rst_mid_cnt", bus.sat_count, 16'd0);
    chk("rst_mid_out", bus.out, 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send("post_rst", 20'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    repeat (3) step();
    chk("final_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

endmodule
